// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes,
// datapath select codes and the control-word payload.
package mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;

    localparam logic [STATE_W-1:0] S_IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] S_FETCH  = 4'd1;
    localparam logic [STATE_W-1:0] S_DECODE = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMADR = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMRD  = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWB  = 4'd5;
    localparam logic [STATE_W-1:0] S_MEMWR  = 4'd6;
    localparam logic [STATE_W-1:0] S_EXEC   = 4'd7;
    localparam logic [STATE_W-1:0] S_ALUWB  = 4'd8;
    localparam logic [STATE_W-1:0] S_BRANCH = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDIEX = 4'd10;
    localparam logic [STATE_W-1:0] S_ADDIWB = 4'd11;
    localparam logic [STATE_W-1:0] S_JUMP   = 4'd12;

    localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational Moore map from sequencer state to datapath controls; only the
// memory-ready gating and the DECODE illegal-opcode flag look at inputs.
module mc_output_decode
    import mc_pkg::*;
(
    input  logic [STATE_W-1:0]  state_i,
    input  logic                mem_ready_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target precomputed here; unknown opcodes end the instruction now
                ctrl_o.alu_src_b  = SRCB_IMM_SH2;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal    = ~is_legal_op(opcode_i);
                ctrl_o.instr_done = ~is_legal_op(opcode_i);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_src     = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer of the multicycle MIPS core: state register and next-state
// logic, with the control word decoded from the current state.
module multicycle_control
    import mc_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_memReady,
    output logic                o_pcWrite,
    output logic                o_pcWriteCond,
    output logic                o_iorD,
    output logic                o_memRead,
    output logic                o_memWrite,
    output logic                o_irWrite,
    output logic                o_memToReg,
    output logic                o_regDst,
    output logic                o_regWrite,
    output logic                o_aluSrcA,
    output logic [1:0]          o_aluSrcB,
    output logic [1:0]          o_aluOp,
    output logic [1:0]          o_pcSrc,
    output logic                o_instrDone,
    output logic                o_illegal
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (i_memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // IR still holds the opcode, so LW/SW can be split here
            S_MEMADR: state_d = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (i_memReady) state_d = S_MEMWB;
            S_MEMWR:  if (i_memReady) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    mc_output_decode u_output_decode (
        .state_i     (state_q),
        .mem_ready_i (i_memReady),
        .opcode_i    (i_opcode),
        .ctrl_o      (ctrl)
    );

    assign o_pcWrite     = ctrl.pc_write;
    assign o_pcWriteCond = ctrl.pc_write_cond;
    assign o_iorD        = ctrl.iord;
    assign o_memRead     = ctrl.mem_read;
    assign o_memWrite    = ctrl.mem_write;
    assign o_irWrite     = ctrl.ir_write;
    assign o_memToReg    = ctrl.mem_to_reg;
    assign o_regDst      = ctrl.reg_dst;
    assign o_regWrite    = ctrl.reg_write;
    assign o_aluSrcA     = ctrl.alu_src_a;
    assign o_aluSrcB     = ctrl.alu_src_b;
    assign o_aluOp       = ctrl.alu_op;
    assign o_pcSrc       = ctrl.pc_src;
    assign o_instrDone   = ctrl.instr_done;
    assign o_illegal     = ctrl.illegal;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencer for the multicycle MIPS core. It decodes the 6-bit opcode latched in the instruction register and steps a Moore-style FSM that drives the PC, memory, IR, register-file and ALU-source enables, and supplies the 2-bit ALU-op to the ALU control decoder. Memory accesses stall on a ready handshake. The block sits between the IR/memory interface and the shared datapath (ALU, register file, PC mux).

## Interface
- No parameters; encodings are fixed in the shared package.
- i_clk  in  1  core clock; all state changes on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_opcode  in  6  IR[31:26]; sampled in DECODE
- i_memReady  in  1  memory has completed the current read/write this cycle
- o_pcWrite  out  1  unconditional PC load
- o_pcWriteCond  out  1  PC load when ALU zero (BEQ)
- o_iorD  out  1  memory address: 0 = PC, 1 = ALUOut
- o_memRead  out  1  memory read request
- o_memWrite  out  1  memory write request
- o_irWrite  out  1  IR load
- o_memToReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- o_regDst  out  1  destination register: 0 = rt, 1 = rd
- o_regWrite  out  1  register-file write enable
- o_aluSrcA  out  1  0 = PC, 1 = A
- o_aluSrcB  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- o_aluOp  out  2  00 = add, 01 = sub, 10 = R-type funct
- o_pcSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- o_instrDone  out  1  one-cycle pulse on the last cycle of every instruction
- o_illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Every output not listed for a state is 0.
- IDLE: all outputs 0; go to FETCH next cycle. This is the reset state.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite and pcWrite equal i_memReady.
  - Hold in FETCH while i_memReady=0; on i_memReady=1 go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
  - LW 100011 or SW 101011 → MEMADR
  - R-type 000000 → EXEC
  - BEQ 000100 → BRANCH
  - ADDI 001000 → ADDIEX
  - J 000010 → JUMP
  - any other opcode → FETCH, with o_illegal=1 and o_instrDone=1
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. LW → MEMRD; SW → MEMWR. The opcode is held stable by the IR.
- MEMRD: memRead=1, iorD=1. Hold until i_memReady, then go to MEMWB.
- MEMWB: regWrite=1, memToReg=1, regDst=0, instrDone=1; → FETCH.
- MEMWR: memWrite=1, iorD=1. Hold until i_memReady; on ready assert instrDone=1 and go to FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10; → ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0, instrDone=1; → FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSrc=01, instrDone=1; → FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00; → ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0, instrDone=1; → FETCH.
- JUMP: pcWrite=1, pcSrc=10, instrDone=1; → FETCH.

## Timing
- Outputs are combinational from the registered state. The only input-dependent terms are:
  - i_memReady gating in FETCH/MEMWR (irWrite, pcWrite, instrDone);
  - i_opcode in DECODE (o_illegal, o_instrDone).
- While i_rst_n=0: state=IDLE and every output is 0. Reset takes effect asynchronously; release is synchronous to the next i_clk edge.
- Reset asserted mid-instruction (including mid memory stall) aborts it immediately. No regWrite, memWrite or pcWrite is asserted after reset assertion.
- Zero-wait cycle counts, FETCH through the last state inclusive:
  - LW 5; SW, R-type and ADDI 4; BEQ and J 3; illegal 2.
  - Each memory wait cycle adds exactly 1.
- i_memReady is ignored in every state except FETCH, MEMRD and MEMWR.
- o_instrDone pulses exactly once per instruction. The next FETCH begins on the following cycle.

## Structure
- Shared package mc_pkg holds:
  - state enum (4-bit encoding, IDLE = 0);
  - opcode constants OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALU-op constants ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10;
  - aluSrcB and pcSrc select constants.
- One natural sub-module: mc_output_decode, a purely combinational map from (state, i_memReady, i_opcode) to all outputs. The top level keeps the state register and next-state logic.

## Test plan
- Reset, then release with i_memReady=1 throughout. Required: 1 IDLE cycle with all outputs 0, then FETCH with memRead=1, irWrite=1, pcWrite=1, aluSrcB=01.
- R-type (opcode 000000), zero waits. Required: DECODE aluSrcB=11; EXEC aluOp=10, aluSrcA=1, aluSrcB=00; ALUWB regWrite=1, regDst=1, instrDone=1; 4 cycles total.
- LW (100011) with i_memReady low for 2 cycles in FETCH and 3 in MEMRD. Required: irWrite only in the ready cycle; MEMWB regWrite=1, memToReg=1; 10 cycles total.
- BEQ (000100) then J (000010). Required:
  - BRANCH: aluOp=01, pcWriteCond=1, pcSrc=01.
  - JUMP: pcWrite=1, pcSrc=10.
  - 3 cycles each, one instrDone pulse each.
- Opcode 111111. Required: o_illegal=1 and instrDone=1 in DECODE, return to FETCH, no regWrite or memWrite.
- SW (101011) stalled in MEMWR, with i_rst_n pulled low mid-stall. Required: memWrite drops to 0 the same cycle; state IDLE; FETCH one cycle after release.
